// File: rtl/game_clock_supervisor.sv
// rtl/game_clock_supervisor.sv - PLL lock supervisor: lock sync, game reset release, loss tracking, gravity tick
module game_clock_supervisor #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int TICK_BASE     = 25000000,
  parameter int TICK_STEP     = 1500000,
  parameter int TICK_MIN      = 2500000
) (
  input  logic       refclk_i,
  input  logic       rst_i,
  input  logic       locked_i,
  input  logic [3:0] level_i,
  input  logic       pause_i,
  input  logic       lost_ack_i,
  output logic       game_rst_n_o,
  output logic       run_o,
  output logic       tick_o,
  output logic       lock_lost_o,
  output logic [7:0] relock_cnt_o
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic signed [32:0] BASE_S = 33'(TICK_BASE);
  localparam logic signed [32:0] STEP_S = 33'(TICK_STEP);
  localparam logic signed [32:0] MIN_S  = 33'(TICK_MIN);

  typedef enum logic [1:0] {S_WAIT, S_STABLE, S_RUN, S_LOST} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SW-1:0]          stab_q, stab_d;
  logic [31:0]            tcnt_q, tcnt_d;
  logic                   tick_q, tick_d;
  logic                   lock_lost_q, lock_lost_d;
  logic [7:0]             relock_q, relock_d;
  logic                   game_rst_n_q, run_q;
  logic                   locked_s, lost_entry;
  logic signed [32:0]     p_raw, period, period_m1;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Signed arithmetic so high levels go negative and clamp to the floor.
  always_comb begin
    p_raw     = BASE_S - $signed({29'd0, level_i}) * STEP_S;
    period    = (p_raw < MIN_S) ? MIN_S : p_raw;
    period_m1 = period - 33'sd1;
  end

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    case (state_q)
      S_WAIT: begin
        stab_d = '0;
        if (locked_s) begin
          state_d = S_STABLE;
          stab_d  = SW'(1);
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_d = S_WAIT;
          stab_d  = '0;
        end else if (stab_q == SW'(STABLE_CYCLES)) begin
          state_d = S_RUN;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end
      S_RUN:   if (!locked_s) state_d = S_LOST;
      S_LOST:  state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  always_comb begin
    tcnt_d = '0;
    tick_d = 1'b0;
    if (state_q == S_RUN) begin
      tcnt_d = tcnt_q;
      if (!pause_i) begin
        if ($signed({1'b0, tcnt_q}) >= period_m1) begin
          tick_d = 1'b1;
          tcnt_d = '0;
        end else begin
          tcnt_d = tcnt_q + 32'd1;
        end
      end
    end
    lost_entry  = (state_d == S_LOST) && (state_q != S_LOST);
    lock_lost_d = lost_entry | (lock_lost_q & ~lost_ack_i);
    relock_d    = (lost_entry && relock_q != 8'hFF) ? relock_q + 8'd1 : relock_q;
  end

  always_ff @(posedge refclk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q       <= '0;
      state_q      <= S_WAIT;
      stab_q       <= '0;
      tcnt_q       <= '0;
      tick_q       <= 1'b0;
      lock_lost_q  <= 1'b0;
      relock_q     <= 8'd0;
      game_rst_n_q <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], locked_i};
      state_q      <= state_d;
      stab_q       <= stab_d;
      tcnt_q       <= tcnt_d;
      tick_q       <= tick_d;
      lock_lost_q  <= lock_lost_d;
      relock_q     <= relock_d;
      game_rst_n_q <= (state_d == S_RUN);
      run_q        <= (state_d == S_RUN);
    end
  end

  assign game_rst_n_o = game_rst_n_q;
  assign run_o        = run_q;
  assign tick_o       = tick_q;
  assign lock_lost_o  = lock_lost_q;
  assign relock_cnt_o = relock_q;
endmodule

// File: tb/tb_game_clock_supervisor.sv
// tb/tb_game_clock_supervisor.sv - directed and random checks of game_clock_supervisor against a behavioural model
module tb_game_clock_supervisor;
  localparam int SS = 2;
  localparam int SC = 8;
  localparam int TB = 20;
  localparam int TS = 2;
  localparam int TM = 4;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic [3:0] level = 4'd0;
  logic       pause = 1'b0;
  logic       lost_ack = 1'b0;
  logic       game_rst_n, run, tick, lock_lost;
  logic [7:0] relock_cnt;

  game_clock_supervisor #(
    .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .TICK_BASE(TB), .TICK_STEP(TS), .TICK_MIN(TM)
  ) dut (
    .refclk_i(refclk), .rst_i(rst_n), .locked_i(locked), .level_i(level),
    .pause_i(pause), .lost_ack_i(lost_ack), .game_rst_n_o(game_rst_n), .run_o(run),
    .tick_o(tick), .lock_lost_o(lock_lost), .relock_cnt_o(relock_cnt)
  );

  always #5 refclk = ~refclk;

  int checks = 0;
  int errors = 0;

  bit lhist [SS];
  bit m_run, m_blackout, m_lost, m_tick;
  int m_streak, m_acc, m_cnt;

  function automatic int period(input int lv);
    int p;
    p = TB - lv * TS;
    if (p < TM) p = TM;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (lhist[i]) lhist[i] = 1'b0;
    m_run = 0; m_blackout = 0; m_lost = 0; m_tick = 0;
    m_streak = 0; m_acc = 0; m_cnt = 0;
  endtask

  // Release needs SC+1 consecutive synchronised-high samples; a loss costs one dead cycle.
  task automatic model_edge();
    bit ls, was_run, set_now;
    ls      = lhist[SS-1];
    was_run = m_run;
    set_now = 0;
    for (int i = SS - 1; i > 0; i--) lhist[i] = lhist[i-1];
    lhist[0] = locked;

    m_tick = 0;
    if (!was_run) m_acc = 0;
    else if (!pause) begin
      m_acc++;
      if (m_acc >= period(int'(level))) begin
        m_tick = 1;
        m_acc  = 0;
      end
    end

    if (m_run) begin
      if (!ls) begin
        m_run = 0; m_blackout = 1; m_streak = 0; set_now = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end else if (m_blackout) begin
      m_blackout = 0; m_streak = 0;
    end else if (ls) begin
      m_streak++;
      if (m_streak > SC) m_run = 1;
    end else begin
      m_streak = 0;
    end

    if (set_now) m_lost = 1;
    else if (lost_ack) m_lost = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge refclk);
      model_edge();
      @(negedge refclk);
      chk("m_game_rst_n", game_rst_n, m_run);
      chk("m_run", run, m_run);
      chk("m_tick", tick, m_tick);
      chk("m_lock_lost", lock_lost, m_lost);
      chk("m_relock_cnt", relock_cnt, m_cnt);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge refclk);
    chk("rst_game_rst_n", game_rst_n, 0);
    chk("rst_run", run, 0);
    chk("rst_tick", tick, 0);
    chk("rst_lock_lost", lock_lost, 0);
    chk("rst_relock_cnt", relock_cnt, 0);
    rst_n = 1'b1;

    locked = 1'b1; step(5);
    locked = 1'b0; step(1);
    locked = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      step(1);
      chk("release_edge", game_rst_n, (e >= 10));
    end
    chk("release_run", run, 1);
    chk("glitch_relock", relock_cnt, 0);

    for (int i = 1; i <= 40; i++) begin step(1); chk("tick_l0", tick, (i % 20 == 0)); end
    level = 4'd3;
    for (int i = 1; i <= 28; i++) begin step(1); chk("tick_l3", tick, (i % 14 == 0)); end
    level = 4'd15;
    for (int i = 1; i <= 8; i++) begin step(1); chk("tick_l15", tick, (i % 4 == 0)); end

    level = 4'd0; step(15);
    level = 4'd5; step(1);
    chk("lvl_change_tick", tick, 1);
    for (int i = 1; i <= 20; i++) begin step(1); chk("tick_l5", tick, (i % 10 == 0)); end

    level = 4'd0; step(19);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin step(1); chk("pause_no_tick", tick, 0); end
    pause = 1'b0; step(1);
    chk("pause_release_tick", tick, 1);
    for (int i = 1; i <= 20; i++) begin step(1); chk("post_pause", tick, (i == 20)); end

    locked = 1'b0;
    step(1); chk("loss_e1", game_rst_n, 1);
    step(1); chk("loss_e2", game_rst_n, 1);
    step(1); chk("loss_e3", game_rst_n, 0);
    chk("loss_flag", lock_lost, 1);
    chk("loss_cnt", relock_cnt, 1);
    step(1);
    for (int i = 0; i < 25; i++) begin step(1); chk("loss_no_tick", tick, 0); end

    locked = 1'b1; step(11);
    chk("relock_run", run, 1);
    locked = 1'b0; step(2);
    lost_ack = 1'b1; step(1);
    chk("ack_vs_set_flag", lock_lost, 1);
    chk("ack_vs_set_cnt", relock_cnt, 2);
    step(1);
    chk("ack_clears", lock_lost, 0);
    lost_ack = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) locked = ~locked;
      if ($urandom_range(0, 49) == 0) level = 4'($urandom_range(0, 15));
      pause    = ($urandom_range(0, 7) == 0);
      lost_ack = ($urandom_range(0, 15) == 0);
      step(1);
    end
    pause = 1'b0; lost_ack = 1'b0;

    locked = 1'b0; step(5);
    for (int i = 0; i < 260; i++) begin
      locked = 1'b1; step(11);
      chk("sat_run", run, 1);
      locked = 1'b0; step(3);
    end
    chk("sat_cnt", relock_cnt, 255);
    chk("sat_flag", lock_lost, 1);

    locked = 1'b1; step(11);
    chk("pre_async_run", run, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_game_rst_n", game_rst_n, 0);
    chk("async_run", run, 0);
    chk("async_tick", tick, 0);
    chk("async_lock_lost", lock_lost, 0);
    chk("async_relock_cnt", relock_cnt, 0);
    model_reset();
    @(negedge refclk);
    rst_n = 1'b1;
    step(11);
    chk("post_async_run", run, 1);
    chk("post_async_cnt", relock_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
